// File: rtl/jtag_scan_checker.sv
// jtag_scan_checker
// TAP-side scan stimulus and response checker. It serialises a REG_WIDTH pattern
// onto TDI, LSB first, while capturing the same number of TDO bits. It then
// compares the captured word with a latched expected word under a per-bit mask.
// The block reports the per-scan result and keeps a saturating count of failing
// scans.
//
// Optional feature: define JTAG_SCAN_BYPASS_EN to add the bypass_mode input.
// With bypass_mode=1, a scan checks a 1-bit BYPASS register. The expected word
// becomes the pattern delayed by one bit, and the unknown first TDO bit is masked.
module jtag_scan_checker #(
    parameter int REG_WIDTH = 14,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 TCK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [REG_WIDTH-1:0] scan_pattern,
    input  logic [REG_WIDTH-1:0] expected,
    input  logic [REG_WIDTH-1:0] compare_mask,
    input  logic                 shift_en,
    input  logic                 from_TDO,
    input  logic                 err_clr,
`ifdef JTAG_SCAN_BYPASS_EN
    input  logic                 bypass_mode,
`endif
    output logic                 to_TDI,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [REG_WIDTH-1:0] mismatch_bits,
    output logic [CNT_WIDTH-1:0] error_count
);

    localparam int BW = $clog2(REG_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [BW-1:0]        LAST_BIT = BW'(REG_WIDTH - 1);
    localparam logic [BW-1:0]        BIT_STEP = BW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] LSB_ONLY = REG_WIDTH'(1);

    logic [1:0]           state_r;
    logic [REG_WIDTH-1:0] tdi_r;
    logic [REG_WIDTH-1:0] tdo_r;
    logic [REG_WIDTH-1:0] exp_r;
    logic [REG_WIDTH-1:0] mask_r;
    logic [BW-1:0]        bit_cnt_r;

    logic [REG_WIDTH-1:0] exp_load_s;
    logic [REG_WIDTH-1:0] mask_load_s;
    logic [REG_WIDTH-1:0] mismatch_s;
    logic                 any_mismatch_s;

    // TDI is bit 0 of the shift register itself, so it only moves on TCK.
    assign to_TDI = tdi_r[0];

    // Select the expected word and mask that are latched when a scan starts.
    always_comb begin
        exp_load_s  = expected;
        mask_load_s = compare_mask;
`ifdef JTAG_SCAN_BYPASS_EN
        if (bypass_mode) begin
            // A 1-bit bypass register delays TDI by one shift.
            // The first TDO bit is stale, so it is not compared.
            exp_load_s  = {scan_pattern[REG_WIDTH-2:0], 1'b0};
            mask_load_s = compare_mask & ~LSB_ONLY;
        end else begin
            exp_load_s  = expected;
            mask_load_s = compare_mask;
        end
`endif
    end

    // Masked difference between captured TDO and the expected word.
    always_comb begin
        mismatch_s     = (tdo_r ^ exp_r) & mask_r;
        any_mismatch_s = |mismatch_s;
    end

    // Scan sequencer: load on start, shift while the TAP shifts, evaluate for one cycle.
    always_ff @(posedge TCK or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            tdi_r         <= {REG_WIDTH{1'b0}};
            tdo_r         <= {REG_WIDTH{1'b0}};
            exp_r         <= {REG_WIDTH{1'b0}};
            mask_r        <= {REG_WIDTH{1'b0}};
            bit_cnt_r     <= {BW{1'b0}};
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            mismatch_bits <= {REG_WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tdi_r     <= scan_pattern;
                        exp_r     <= exp_load_s;
                        mask_r    <= mask_load_s;
                        bit_cnt_r <= {BW{1'b0}};
                        busy      <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // With shift_en low, the scan pauses and all state holds.
                    if (shift_en) begin
                        tdi_r     <= {1'b0, tdi_r[REG_WIDTH-1:1]};
                        tdo_r     <= {from_TDO, tdo_r[REG_WIDTH-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_STEP;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    mismatch_bits <= mismatch_s;
                    error         <= any_mismatch_s;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Count failing scans, saturating at all-ones; a clear beats a same-cycle increment.
    always_ff @(posedge TCK or posedge reset) begin
        if (reset) begin
            error_count <= {CNT_WIDTH{1'b0}};
        end else if (err_clr) begin
            error_count <= {CNT_WIDTH{1'b0}};
        end else if ((state_r == ST_CHECK) && any_mismatch_s && (error_count != CNT_MAX)) begin
            error_count <= error_count + CNT_ONE;
        end
    end

endmodule

// File: doc/jtag_scan_checker.md
# jtag_scan_checker

Parametrised TAP-side scan stimulus and response checker for the boundary-scan testbench. It serialises a REG_WIDTH pattern onto TDI and captures the same number of TDO bits. It compares the captured word against a latched expected word under a per-bit mask, then reports the per-scan result and a saturating error count. It sits between the bench sequencer and the ASIC TAP. It replaces the separate TDI generator/TDO monitor pair and their hierarchical shift-enable probe with a start/done handshake and an explicit `shift_en` port.

## Interface
- REG_WIDTH, 14, scan register length in bits (≥2)
- CNT_WIDTH, 8, width of error counter
- TCK  input  1  test clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a scan; sampled only in IDLE
- scan_pattern  input  REG_WIDTH  pattern to shift; bit 0 goes out first
- expected  input  REG_WIDTH  expected TDO word, latched at start
- compare_mask  input  REG_WIDTH  1 = compare bit, 0 = ignore; latched at start
- shift_en  input  1  TAP is in Shift-DR/IR this cycle (driven by the TAP controller)
- from_TDO  input  1  serial data from ASIC
- err_clr  input  1  synchronous clear of error_count
- to_TDI  output  1  serial data to ASIC = TDI shift register bit 0
- busy  output  1  high in SHIFT and CHECK
- done  output  1  one-cycle pulse, result valid
- error  output  1  1 if the last completed scan had any masked mismatch
- mismatch_bits  output  REG_WIDTH  (captured ^ expected) & mask of the last scan
- error_count  output  CNT_WIDTH  number of failing scans; saturates at all-ones

## Operation
- States: IDLE, SHIFT, CHECK. Reset → IDLE. All registers and outputs are 0 after reset: to_TDI, busy, done, error, mismatch_bits, error_count, and the bit counter.
- IDLE with start=1: load tdi_reg←scan_pattern, exp_reg←expected, mask_reg←compare_mask, bit_cnt←0, then → SHIFT.
- IDLE with start=0: hold. In IDLE, to_TDI keeps showing tdi_reg[0].
- SHIFT, shift_en=1: tdi_reg←tdi_reg>>1 (zero fill), tdo_reg←{from_TDO, tdo_reg[W-1:1]}, bit_cnt++. On the shift where bit_cnt==REG_WIDTH-1 → CHECK.
- SHIFT, shift_en=0: everything holds (pause). The number of pauses is unbounded.
- CHECK (exactly one cycle): mismatch_bits←(tdo_reg^exp_reg)&mask_reg, error←|mismatch, error_count +1 if error (saturating), done←1, then → IDLE.
- tdo_reg bit k holds the TDO bit captured on shift k (k = 0 first).
- start while busy is ignored; no queuing.
- err_clr=1: error_count←0. If err_clr coincides with an increment, the clear wins. err_clr does not affect error or mismatch_bits.
- reset during SHIFT or CHECK aborts the scan. There is no done pulse and error_count becomes 0.
- error and mismatch_bits hold until the next CHECK.

## Timing
- start sampled at edge 0. Shifts occur at edges 1..REG_WIDTH when shift_en is held high. CHECK is evaluated at edge REG_WIDTH+1. done is high for the cycle following that edge.
- Start-to-done latency is REG_WIDTH+1 cycles plus the number of shift_en-low cycles in SHIFT.
- busy rises after edge 0 and falls after edge REG_WIDTH+1, in the same cycle done rises.
- done and start may both be high in the same cycle. The new scan is accepted, giving back-to-back scans with one idle cycle.
- to_TDI is registered-only. It changes only on posedge TCK.

## Configuration
- `JTAG_SCAN_BYPASS_EN` defined:
  - Adds input `bypass_mode` (1 bit), sampled at start.
  - If bypass_mode=1, exp_reg is latched as {scan_pattern[W-2:0],1'b0} and mask_reg as compare_mask & ~1. This checks a 1-bit BYPASS register, whose first TDO bit is unknown.
- Undefined: the port is absent and expected/compare_mask are always used as given.

## Test plan
- Loopback (from_TDO=to_TDI), scan_pattern=expected=14'h2A5C, mask=14'h3FFF, shift_en high → done at cycle 15, error=0, mismatch_bits=0, error_count=0.
- Same stimulus but expected=14'h2A5D → error=1, mismatch_bits=14'h0001, error_count=1. Then with mask=14'h3FFE → error=0 and error_count stays 1.
- shift_en low for 3 cycles mid-scan, start re-pulsed while busy → done at cycle 18, one scan only, correct result.
- CNT_WIDTH=2, 5 failing scans → error_count 1,2,3,3,3. err_clr in the same cycle as the 6th CHECK → 0.
- reset asserted at shift 7 → all outputs 0 immediately, no done, next scan completes normally.
- JTAG_SCAN_BYPASS_EN, bench models a 1-bit bypass register, bypass_mode=1, pattern 14'h1234 → error=0. The same scan with bypass_mode=0 and expected=14'h1234 → error=1.
